// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions: multiply/divide op encodings (also decoded by
// the ALU control decoder) and the muldiv FSM state encoding.
package kgp_risc_pkg;

  // Multiply/divide op field
  localparam logic [1:0] OP_MUL  = 2'b00;  // low half of product
  localparam logic [1:0] OP_MULH = 2'b01;  // high half of product (unsigned)
  localparam logic [1:0] OP_DIVU = 2'b10;  // quotient
  localparam logic [1:0] OP_REMU = 2'b11;  // remainder

  // Muldiv FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  // Divide ops share op[1]; the result comes from the upper accumulator half
  // (high product / remainder) whenever op[0] is set.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_takes_high(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiplier or divider (purely combinational).
// Ports:
//   is_div   - 1 selects restoring divide step, 0 selects shift-add multiply
//   acc      - 2*WIDTH accumulator {high, low}
//   mcand    - multiplicand (multiply only)
//   divisor  - divisor (divide only)
//   acc_next - accumulator after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits; add the
    // multiplicand into the high half when the current LSB is set, then
    // shift the whole accumulator right (carry lands in the MSB).
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

    // Divide: low half holds dividend bits, shifted out MSB-first into the
    // partial remainder while quotient bits shift in at the LSB. Compare
    // rather than test the borrow so a zero divisor always "fits", which
    // gives an all-ones quotient and leaves the dividend as remainder.
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, divisor};
    rem_ge    = (rem_shift >= {1'b0, divisor});

    if (is_div) begin
      acc_next = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], rem_ge};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with register-bank writeback.
// Accepts an op in IDLE, runs WIDTH radix-2 iterations, then pulses RegWrite
// for one cycle with the selected result.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   start, kill     - request (IDLE only) / synchronous abort of RUN
//   op              - MUL, MULH, DIVU, REMU
//   rdDataA/B       - operands from register bank ports A/B
//   dstAddr         - destination register index
//   busy            - high in RUN and WB
//   RegWrite        - one-cycle write enable in WB
//   wrAddr, wrData  - write address/data, zero outside WB
module muldiv_unit
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rdDataA,
  input  logic [WIDTH-1:0] rdDataB,
  input  logic [4:0]       dstAddr,
  output logic             busy,
  output logic             RegWrite,
  output logic [4:0]       wrAddr,
  output logic [WIDTH-1:0] wrData
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [4:0]         dst_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   result;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_is_div(op_reg)),
    .acc      (acc_reg),
    .mcand    (mcand_reg),
    .divisor  (divisor_reg),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      mcand_reg   <= '0;
      divisor_reg <= '0;
      dst_reg     <= '0;
      acc_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !kill) begin
            op_reg      <= op;
            mcand_reg   <= rdDataA;
            divisor_reg <= rdDataB;
            dst_reg     <= dstAddr;
            cnt_reg     <= '0;
            // Multiply seeds the low half with the multiplier, divide with
            // the dividend; the high half starts at zero either way.
            acc_reg     <= op_is_div(op) ? {{WIDTH{1'b0}}, rdDataA}
                                         : {{WIDTH{1'b0}}, rdDataB};
            state_reg   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (kill) begin
            state_reg <= ST_IDLE;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (cnt_reg == LAST_ITER) begin
              state_reg <= ST_WB;
            end
          end
        end
        // The write in WB is already committed; kill is not consulted here.
        ST_WB:   state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign result   = op_takes_high(op_reg) ? acc_reg[2*WIDTH-1:WIDTH]
                                          : acc_reg[WIDTH-1:0];
  assign busy     = (state_reg != ST_IDLE);
  assign RegWrite = (state_reg == ST_WB);
  assign wrAddr   = RegWrite ? dst_reg : '0;
  assign wrData   = RegWrite ? result  : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected writes, a
// negedge monitor pops and compares address, data and writeback cycle.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rd_a = '0;
  logic [W-1:0] rd_b = '0;
  logic [4:0]   dst = '0;
  logic         busy;
  logic         reg_write;
  logic [4:0]   wr_addr;
  logic [W-1:0] wr_data;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .kill     (kill),
    .op       (op),
    .rdDataA  (rd_a),
    .rdDataB  (rd_b),
    .dstAddr  (dst),
    .busy     (busy),
    .RegWrite (reg_write),
    .wrAddr   (wr_addr),
    .wrData   (wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [4:0]   addr;
    logic [W-1:0] data;
    int           cyc;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the oldest expected entry; outside WB
  // the write port must be quiet.
  always @(negedge clk) begin
    if (reset) begin
      if (reg_write) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%08h, required no write",
                   wr_addr, wr_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("WB %s addr=%0d data=0x%08h cyc=%0d", e.name, wr_addr, wr_data, cyc);
          check({e.name, "_addr"}, 64'(wr_addr), 64'(e.addr));
          check({e.name, "_data"}, 64'(wr_data), 64'(e.data));
          check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("idle_port_zero", {27'd0, wr_addr, wr_data}, 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] d, input logic push, input logic [W-1:0] exp_data,
                       input string name);
    exp_t e;
    op = o; rd_a = a; rd_b = b; dst = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.addr = d; e.data = exp_data; e.cyc = cyc + W; e.name = name;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Counts busy negedges (starting at the current one) until busy drops.
  task automatic wait_idle(output int nbusy);
    int guard;
    nbusy = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      nbusy++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: got busy still high after %0d cycles, required idle", guard);
    end
  endtask

  int nb;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_regwrite", 64'(reg_write), 64'd0);
    check("reset_port", {27'd0, wr_addr, wr_data}, 64'd0);
    reset = 1'b1;

    // First edge after release accepts; MUL 7*6
    issue(2'b00, 32'd7, 32'd6, 5'd10, 1'b1, 32'd42, "mul_7x6");
    wait_idle(nb);
    check("mul_busy_cycles", 64'(nb), 64'(W + 1));

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'hFFFF_FFFE, "mulh_max");
    wait_idle(nb);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'h0000_0001, "mul_max");
    wait_idle(nb);
    issue(2'b10, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14, "divu_100_7");
    wait_idle(nb);
    issue(2'b11, 32'd100, 32'd7, 5'd4, 1'b1, 32'd2, "remu_100_7");
    wait_idle(nb);
    issue(2'b10, 32'd5, 32'd0, 5'd5, 1'b1, 32'hFFFF_FFFF, "divu_by0");
    wait_idle(nb);
    check("divu_by0_busy_cycles", 64'(nb), 64'(W + 1));
    issue(2'b11, 32'd5, 32'd0, 5'd6, 1'b1, 32'd5, "remu_by0");
    wait_idle(nb);

    // Reset at RUN cycle 10 discards the op
    issue(2'b00, 32'd11, 32'd13, 5'd9, 1'b0, 32'd0, "mul_reset");
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_port", {26'd0, reg_write, wr_addr, wr_data}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("after_reset_busy", 64'(busy), 64'd0);
    issue(2'b00, 32'd3, 32'd3, 5'd8, 1'b1, 32'd9, "mul_3x3");
    wait_idle(nb);

    // Kill at RUN cycle 5
    issue(2'b10, 32'd100, 32'd7, 5'd12, 1'b0, 32'd0, "divu_kill");
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", 64'(busy), 64'd0);
    // start together with kill in IDLE is refused
    op = 2'b00; rd_a = 32'd2; rd_b = 32'd2; dst = 5'd13; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("start_kill_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Start while busy is ignored; input changes don't disturb the op
    issue(2'b00, 32'd2, 32'd3, 5'd14, 1'b1, 32'd6, "mul_2x3");
    repeat (4) @(negedge clk);
    op = 2'b11; rd_a = 32'd9; rd_b = 32'd4; dst = 5'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(nb);
    issue(2'b11, 32'd9, 32'd4, 5'd15, 1'b1, 32'd1, "remu_9_4");
    wait_idle(nb);

    // Kill during WB does not suppress the write
    issue(2'b00, 32'h1234_5678, 32'h10, 5'd16, 1'b1, 32'h2345_6780, "mul_killwb");
    for (int i = 0; i < 50 && reg_write !== 1'b1; i++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("killwb_busy", 64'(busy), 64'd0);

    // Back-to-back: second op accepted in the first IDLE cycle
    issue(2'b10, 32'hFFFF_FFFF, 32'h10, 5'd17, 1'b1, 32'h0FFF_FFFF, "divu_b2b");
    wait_idle(nb);
    issue(2'b11, 32'h1234_5678, 32'h100, 5'd18, 1'b1, 32'h78, "remu_b2b");
    wait_idle(nb);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL take one parameter: WIDTH, default 32, operand/result width; the iteration count equals WIDTH.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset: clk is the single clock, and reset asserted low clears all state immediately, independent of clk.
REQ-003 clk  input  1  rising-edge clock shared with the register bank.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 kill  input  1  synchronous abort of the in-flight operation (pipeline flush).
REQ-007 op  input  2  00 MUL (low product), 01 MULH (high product, unsigned), 10 DIVU (quotient), 11 REMU (remainder).
REQ-008 rdDataA  input  WIDTH  operand A (multiplicand/dividend), from register bank port A.
REQ-009 rdDataB  input  WIDTH  operand B (multiplier/divisor), from register bank port B.
REQ-010 dstAddr  input  5  destination register index.
REQ-011 busy  output  1  high while an operation is accepted and not yet written back.
REQ-012 RegWrite  output  1  register bank write enable, one-cycle pulse.
REQ-013 wrAddr  output  5  register bank write address.
REQ-014 wrData  output  WIDTH  register bank write data.

Function
REQ-015 FSM states SHALL be IDLE, RUN, WB; reset state IDLE.
REQ-016 IDLE: start=1 and kill=0 at a rising edge SHALL latch op, rdDataA, rdDataB, dstAddr, clear the iteration counter, and enter RUN.
REQ-017 Operands SHALL be used only from latched copies; input changes after acceptance SHALL have no effect.
REQ-018 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply (2*WIDTH-bit accumulator), restoring shift-subtract for divide.
REQ-019 After exactly WIDTH RUN cycles the FSM SHALL enter WB; WB lasts one cycle, then IDLE.
REQ-020 RegWrite SHALL be high only in WB, for exactly one cycle, i.e. WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
REQ-021 In WB, wrAddr SHALL equal latched dstAddr and wrData the op-selected result; outside WB both SHALL be 0.
REQ-022 busy SHALL be high in RUN and WB, low in IDLE (registered, not a combinational function of start).
REQ-023 All arithmetic SHALL be unsigned; MUL/MULH are bits [WIDTH-1:0]/[2*WIDTH-1:WIDTH] of the full product.
REQ-024 Divisor 0: DIVU SHALL yield all ones, REMU SHALL yield the dividend; latency unchanged.
REQ-025 start while busy SHALL be ignored (no queueing, latched values unchanged).
REQ-026 kill=1 in RUN SHALL return to IDLE at the next edge with no write; kill=1 in IDLE SHALL block acceptance of a simultaneous start.
REQ-027 kill in WB SHALL NOT suppress the write in progress.
REQ-028 A new start SHALL be accepted in the IDLE cycle after WB (back-to-back throughput = one op per WIDTH+2 cycles).

Reset
REQ-029 reset low SHALL force IDLE and busy=0, RegWrite=0, wrAddr=0, wrData=0, counter=0, operand/accumulator registers=0.
REQ-030 reset asserted mid-RUN or mid-WB SHALL discard the operation; no write SHALL occur after release.
REQ-031 After reset release, the first rising edge SHALL be able to accept start.

Structure
REQ-032 Op encodings (MUL, MULH, DIVU, REMU) and the FSM state encoding SHALL live in the shared KGP-RISC package, shared with the ALU control decoder.
REQ-033 One combinational sub-module, muldiv_step, SHALL compute a single multiply or divide iteration; muldiv_unit holds FSM, counter and registers.

Verification
REQ-034 MUL A=7, B=6, dstAddr=10 -> busy for 33 cycles, single RegWrite pulse, wrAddr=10, wrData=42.
REQ-035 MULH A=B=0xFFFFFFFF -> wrData=0xFFFFFFFE; MUL same operands -> wrData=0x00000001.
REQ-036 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-037 MUL started, reset low at RUN cycle 10, released 2 cycles later -> busy=0, no RegWrite ever for that op; next MUL 3*3 -> 9.
REQ-038 DIVU started, kill at RUN cycle 5 -> IDLE next cycle, no write; start+kill together in IDLE -> not accepted.
REQ-039 MUL 2*3 in flight, start REMU 9/4 at cycle 5 -> ignored; single write of 6; REMU reissued in IDLE -> 1.
